// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and bit-counter width helper for serial_nbit_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/serial_nbit_adder_full_adder.sv
// full_adder: 1-bit combinational full adder cell; ports a, b, cin -> s, cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_nbit_adder.sv
// serial_nbit_adder: bit-serial N-bit adder, LSB first; ports clk, rst(async high), start, a, b, cin -> busy, done, sum, cout, ovf (ovf only with SERIAL_ADDER_OVF_EN)
module serial_nbit_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int CNT_W = cnt_w(N);
  sadd_state_t state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0] a_sh, b_sh, s_sh, s_nx;
  logic carry, fa_s, fa_co, last, load;
  full_adder u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(fa_s), .cout(fa_co));
  assign last = cnt == CNT_W'(N - 1);
  assign load = start && state != RUN;
  assign s_nx = {fa_s, s_sh[N-1:1]};
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_d = state;
    state_d = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      carry <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      a_sh <= a;
      b_sh <= b;
      carry <= cin;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_nx;
      carry <= fa_co;
      if (last) begin
        sum <= s_nx;
        cout <= fa_co;
      end
    end
`ifdef SERIAL_ADDER_OVF_EN
  // on the last bit, carry holds the carry into bit N-1
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= carry ^ fa_co;
`endif
endmodule

// File: tb/tb_serial_nbit_adder.sv
// tb_serial_nbit_adder: randomized self-checking bench for serial_nbit_adder against a + b + cin
module tb_serial_nbit_adder;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [N-1:0] sum;
  int checks = 0, failures = 0;
  serial_nbit_adder #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N:0] ref_sum(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
  endfunction
  function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] r;
    r = ref_sum(x, y, c);
    return (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
  endfunction
  task automatic check_result(input string tag, input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] r;
    r = ref_sum(x, y, c);
    check({tag, "_sum"}, 64'(sum), 64'(r[N-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(r[N]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(x, y, c)));
`endif
  endtask
  task automatic wait_done(input string tag, output int busy_n);
    int t;
    busy_n = 0;
    t = 0;
    while (!done && t < 4 * N) begin
      if (busy) busy_n++;
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
  endtask
  task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    int bn;
    @(negedge clk);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    cin = 1'($urandom);
    wait_done(tag, bn);
    check({tag, "_busy_cycles"}, 64'(bn), 64'(N));
    check({tag, "_busy_in_done"}, 64'(busy), 64'(0));
    check_result(tag, x, y, c);
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'(0));
    check_result({tag, "_hold"}, x, y, c);
  endtask
  initial begin
    int bn, gap;
    logic [N-1:0] x, y;
    logic c;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    do_op("10p5", 8'd10, 8'd5, 1'b0);
    do_op("255p1", 8'd255, 8'd1, 1'b0);
    do_op("200p100c", 8'd200, 8'd100, 1'b1);
    do_op("100p100", 8'd100, 8'd100, 1'b0);
    do_op("80p80", 8'h80, 8'h80, 1'b0);
    do_op("ff_ff_c", 8'hff, 8'hff, 1'b1);
    do_op("zero", 8'd0, 8'd0, 1'b0);
    // start while busy is ignored
    @(negedge clk);
    a = 8'd20; b = 8'd22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd99; b = 8'd77; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", bn);
    check_result("ignore", 8'd20, 8'd22, 1'b0);
    @(negedge clk);
    // asynchronous reset in the middle of RUN
    a = 8'd50; b = 8'd60; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_sum", 64'(sum), 64'(0));
    check("async_rst_cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bn = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (done) bn++;
    end
    check("rst_no_done", 64'(bn), 64'(0));
    do_op("3p4", 8'd3, 8'd4, 1'b0);
    // start held high through DONE: second op accepted back to back
    @(negedge clk);
    a = 8'd17; b = 8'd33; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    wait_done("b2b1", bn);
    check_result("b2b1", 8'd17, 8'd33, 1'b1);
    a = 8'd120; b = 8'd9; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 4 * N) begin
      check_result("b2b_hold", 8'd17, 8'd33, 1'b1);
      @(negedge clk);
      gap++;
    end
    check("b2b_spacing", 64'(gap), 64'(N + 1));
    check_result("b2b2", 8'd120, 8'd9, 1'b0);
    @(negedge clk);
    repeat (1000) begin
      x = N'($urandom);
      y = N'($urandom);
      c = 1'($urandom);
      do_op("rand", x, y, c);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
